// File: rtl/phased_lookup_ctrl.sv
// Tag/data phase sequencer for a 4-way phased cache: tag compare, single-way data enable, miss fill.
// Define LOOKUP_STATS_EN to add saturating hit_count/miss_count outputs.
//
// state    | meaning
// IDLE     | waiting for a request, req_ready high
// TAG      | tag arrays read at index, hit vector evaluated
// DATA     | data_rd_en on the winning way only
// RESP     | resp_valid pulse, resp_hit = original lookup outcome
// MISS_REQ | mem_req held until mem_ack
// FILL     | load_way/tag_wr into victim, then re-lookup
module phased_lookup_ctrl #(
  parameter int TAG_W = 26,
  parameter int IDX_W = 2,
  parameter int OFF_W = 4
) (
`ifdef LOOKUP_STATS_EN
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count,
`endif
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic [4*TAG_W-1:0]         tag_rd,
  output logic [IDX_W-1:0]           index,
  output logic [(1<<IDX_W)-1:0]      index_dec,
  output logic [3:0]                 load_way,
  output logic [TAG_W-1:0]           tag_wr,
  output logic                       data_rd_en,
  output logic [3:0]                 data_way_sel,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic                       mem_req,
  output logic [31-OFF_W:0]          mem_addr,
  input  logic                       mem_ack
);

  localparam int NSETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TAG      = 3'd1,
    DATA     = 3'd2,
    RESP     = 3'd3,
    MISS_REQ = 3'd4,
    FILL     = 3'd5
  } state_t;

  state_t              state;
  logic [TAG_W-1:0]    lat_tag;
  logic [IDX_W-1:0]    lat_idx;
  logic [31-OFF_W:0]   lat_blk;
  logic                miss_flag;
  logic [3:0]          valid [NSETS];
  logic [1:0]          ptr [NSETS];

  logic [3:0]          hit_vec;
  logic [3:0]          hit_first;
  logic [3:0]          free_vec;
  logic                all_valid;
  logic [3:0]          victim;

  // The block offset never reaches the lookup path.
  logic                unused_offset;
  assign unused_offset = ^req_addr[OFF_W-1:0];

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < 4; w++) begin
      hit_vec[w] = valid[lat_idx][w] && (tag_rd[w*TAG_W +: TAG_W] == lat_tag);
    end
    // x & -x isolates the lowest set bit: lowest way wins on multi-hit / first free way
    hit_first = hit_vec & (~hit_vec + 4'd1);
    free_vec  = ~valid[lat_idx];
    all_valid = (free_vec == 4'd0);
    victim    = all_valid ? (4'b0001 << ptr[lat_idx]) : (free_vec & (~free_vec + 4'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_tag      <= '0;
      lat_idx      <= '0;
      lat_blk      <= '0;
      miss_flag    <= 1'b0;
      for (int s = 0; s < NSETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
      req_ready    <= 1'b1;
      index        <= '0;
      index_dec    <= '0;
      load_way     <= '0;
      tag_wr       <= '0;
      data_rd_en   <= 1'b0;
      data_way_sel <= '0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      resp_valid <= 1'b0;
      data_rd_en <= 1'b0;
      load_way   <= '0;
      tag_wr     <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_tag   <= req_addr[31 -: TAG_W];
            lat_idx   <= req_addr[OFF_W +: IDX_W];
            lat_blk   <= req_addr[31:OFF_W];
            index     <= req_addr[OFF_W +: IDX_W];
            index_dec <= {{(NSETS-1){1'b0}}, 1'b1} << req_addr[OFF_W +: IDX_W];
            req_ready <= 1'b0;
            state     <= TAG;
          end
        end
        TAG: begin
          if (hit_vec != 4'd0) begin
            data_rd_en   <= 1'b1;
            data_way_sel <= hit_first;
            state        <= DATA;
          end else begin
            miss_flag <= 1'b1;
            mem_req   <= 1'b1;
            mem_addr  <= lat_blk;
            state     <= MISS_REQ;
          end
        end
        DATA: begin
          data_way_sel <= '0;
          resp_valid   <= 1'b1;
          resp_hit     <= !miss_flag;
          state        <= RESP;
        end
        RESP: begin
          resp_hit  <= 1'b0;
          miss_flag <= 1'b0;
          index     <= '0;
          index_dec <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        MISS_REQ: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            load_way <= victim;
            tag_wr   <= lat_tag;
            // Round-robin only advances when every way is occupied.
            if (all_valid) ptr[lat_idx] <= ptr[lat_idx] + 2'd1;
            state    <= FILL;
          end
        end
        FILL: begin
          valid[lat_idx] <= valid[lat_idx] | load_way;
          state          <= TAG;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOOKUP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == DATA) begin
      if (!miss_flag && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (miss_flag && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/phased_lookup_ctrl.md
Name: phased_lookup_ctrl

Overview:
Phase-1/phase-2 lookup controller for the 4-way phased cache, directly upstream of the per-way tag arrays and data arrays.
- Splits the request address and drives index/index_dec to all four tag arrays.
- Compares the returned tags against the request tag in the tag phase, then enables only the hit way's data array in the data phase.
- On a miss, sequences the memory request and the tag fill: load to the victim way, using the tag arrays' tagIn input.

Parameters:
TAG_W, 26, tag width; address bits [31:6].
IDX_W, 2, index width; address bits [5:4]; 4 sets.
OFF_W, 4, block offset width; address bits [3:0].

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  lookup request.
req_ready  out  1  high only in IDLE.
req_addr  in  32  byte address; captured on accept.
tag_rd  in  4*TAG_W  combinational tagOut of ways 3..0, concatenated with way0 in the LSBs.
index  out  IDX_W  set index to all tag arrays.
index_dec  out  4  one-hot decode of index.
load_way  out  4  one-hot load to the victim way's tag array.
tag_wr  out  TAG_W  tag written on fill (tagIn).
data_rd_en  out  1  phase-2 data array enable.
data_way_sel  out  4  one-hot hit way for the data phase.
resp_valid  out  1  one-cycle completion pulse.
resp_hit  out  1  1 = original lookup hit; qualified by resp_valid.
mem_req  out  1  block fetch request.
mem_addr  out  28  block address, req_addr[31:4].
mem_ack  in  1  fetch complete.

Behaviour:
- Reset (async, high):
  - State goes to IDLE; all outputs 0 except req_ready=1.
  - 16 valid bits (4 sets x 4 ways) cleared; the four 2-bit round-robin pointers cleared.
  - Reset mid-operation abandons the access and drops mem_req immediately.
- Address latch:
  - On req_valid & req_ready, latch tag = addr[31:6], idx = addr[5:4], blk = addr[31:4].
  - index and index_dec are driven from the latch in every non-IDLE state; they are 0 in IDLE.
- TAG (1 cycle):
  - hit_vec[w] = valid[idx][w] & (tag_rd[w] == latched tag).
  - If any hit: go to DATA. If several ways hit, the lowest-numbered way wins.
  - Else: set the sticky miss flag and go to MISS_REQ.
- DATA (1 cycle): data_rd_en=1; data_way_sel = registered one-hot of the winning hit way. Go to RESP.
- RESP (1 cycle):
  - resp_valid=1; resp_hit = !miss flag.
  - Clear the miss flag; go to IDLE.
- MISS_REQ: hold mem_req=1 and mem_addr=blk until mem_ack=1, then go to FILL. mem_ack in any other state is ignored.
- FILL (1 cycle):
  - Victim is the lowest-numbered invalid way of set idx. If all ways are valid, the victim is pointer[idx], and pointer[idx] increments mod 4. The pointer does not advance when an invalid way is used.
  - load_way = one-hot victim; tag_wr = latched tag.
  - Set valid[idx][victim]; go to TAG. The re-lookup must hit.
- Latency:
  - Hit: accept at cycle 0, TAG at 1, DATA at 2, resp_valid at 3.
  - Miss: 3 + (cycles in MISS_REQ) + 2.
- req_valid while not in IDLE is not accepted (req_ready=0) and must be held by the requester.
- At most one load_way bit is high, and only in FILL.

Optional Feature:
LOOKUP_STATS_EN:
- Adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0.
- hit_count increments at RESP when resp_hit=1; miss_count increments at RESP when resp_hit=0. Both saturate at 0xFFFF (no wrap).
- Without the macro, the ports and counters are absent and there is no other behaviour change.

Test Plan:
- Reset, then request addr 0x00001234 (idx=3, tag=0x48) with all ways invalid → mem_req high, mem_addr=0x0000123; ack → load_way=0001, tag_wr=0x48, index_dec=1000; resp_valid with resp_hit=0.
- Repeat 0x00001234 with tag_rd way0=0x48 → resp_valid on cycle 3, resp_hit=1, data_way_sel=0001, data_rd_en high on cycle 2 only.
- Fill set 3 with tags 0x48, 0x49, 0x4A, 0x4B, then miss on tag 0x4C → victim way0 (pointer 0→1); next miss on 0x4D → way1.
- Hold mem_ack low 5 cycles in MISS_REQ, pulse mem_ack in IDLE → mem_req stays stable 5 cycles; the stray ack causes no state change.
- Assert reset during MISS_REQ → mem_req=0 same cycle; req_ready=1; next lookup of a previously filled address misses (valid bits cleared).
- LOOKUP_STATS_EN: 3 hits and 2 misses → hit_count=3, miss_count=2; force hit_count to 0xFFFF, one more hit → stays 0xFFFF.
